// File: rtl/vcu_ram_pkg.sv
// Shared constants and FSM state type for the buffer-RAM read path.
package vcu_ram_pkg;

    localparam int unsigned DATA_W    = 512;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Bundles the command, RAM read port and output stream of the buffer reader.
// The slave view belongs to the reader; the master view to its environment.
interface ram_stream_reader_if #(
    parameter int unsigned DATA_W = vcu_ram_pkg::DATA_W,
    parameter int unsigned ADDR_W = vcu_ram_pkg::ADDR_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;

    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
        output cmd_ready, r_en, r_addr, m_valid, m_data, m_last, busy, done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
        input  cmd_ready, r_en, r_addr, m_valid, m_data, m_last, busy, done
    );

endinterface

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding RAM words (plus last-beat tag) for the reader.
// The head entry is presented straight from the storage registers, so the
// output never depends combinationally on the read enable.
module ram_rd_fifo #(
    parameter int unsigned WIDTH = 513,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    // Qualify the pop so an empty FIFO can never underflow.
    always_comb begin
        do_wr = wr_en_i;
        do_rd = rd_en_i && (count_q != '0);
    end

    // Storage, pointers and occupancy; a write and a read together keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side controller for the buffer RAM: takes a burst command, issues
// credit-limited reads with one cycle of RAM latency, and returns the words
// as a valid/ready stream with last-beat marking and address wrap-around.
module ram_stream_reader #(
    parameter int unsigned DATA_W     = vcu_ram_pkg::DATA_W,
    parameter int unsigned ADDR_W     = vcu_ram_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    ram_stream_reader_if.slave bus
);

    import vcu_ram_pkg::*;

    localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     FIFO_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE    = (ADDR_W+1)'(1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              pending_q;
    logic              pend_last_q;
    logic              done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              issue;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic              credit_ok;
    logic              fifo_valid;
    logic              fifo_pop;
    logic              last_pop;
    logic [DATA_W:0]   fifo_out;

    // Credit: words already buffered plus the read still in the RAM pipeline.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
        credit_ok = (occupancy < FIFO_LIMIT);
        fifo_pop  = fifo_valid && bus.m_ready;
        last_pop  = fifo_pop && fifo_out[DATA_W];
    end

    // Next-state, read issue and counter updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d = bus.cmd_addr;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = bus.cmd_len;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok && (rem_q != '0)) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged word is the last one out, so its handshake
                // also means the FIFO has emptied.
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Hold off new commands during the done cycle.
        cmd_ready_d = (state_d == IDLE) && !done_d;
    end

    // State, counters, read pipeline tracking and registered handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pending_q   <= issue;
            pend_last_q <= issue && (rem_q == LEN_ONE);
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    ram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pending_q),
        .wr_data_i ({pend_last_q, bus.r_data}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_out),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.r_en      = issue;
    assign bus.r_addr    = addr_q;
    assign bus.m_valid   = fifo_valid;
    assign bus.m_data    = fifo_out[DATA_W-1:0];
    assign bus.m_last    = fifo_out[DATA_W];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural buffer RAM with one cycle of read
// latency, scoreboard of expected beats filled when each command is issued.
module tb_ram_stream_reader;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 10;
    localparam int unsigned FD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_stream_reader #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ram [1024];

    always @(posedge clk) begin
        if (bus.r_en) bus.r_data <= ram[bus.r_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_pass;

    logic [DW-1:0] exp_data_q[$];
    logic          exp_last_q[$];
    int            raddr_log[$];

    int hs_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
    int beats, ren_count, mvalid_count, busy_after_hs;

    function automatic logic [DW-1:0] word(input int unsigned a);
        return {16{a}};
    endfunction

    // Issue one command (entered just after a rising edge) and run until done,
    // timeout, or abort_after cycles; leaves just after a rising edge.
    task automatic drive_burst(input int unsigned addr, input int unsigned len,
                               input int unsigned stall_pct, input int unsigned abort_after);
        int            outstanding;
        int            wait_n;
        int            budget;
        int            cred_viol;
        int            stab_viol;
        bit            got_done;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW-1:0] ed;
        logic          el;
        first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        beats = 0; ren_count = 0; mvalid_count = 0; busy_after_hs = 0;
        raddr_log.delete();
        for (int unsigned k = 0; k < len; k++) begin
            exp_data_q.push_back(word((addr + k) % 1024));
            exp_last_q.push_back(k == len - 1);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = (AW+1)'(len);
        wait_n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!bus.cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_accept: cmd_ready stayed %0b for 50 cycles, required 1", bus.cmd_ready);
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            exp_data_q.delete();
            exp_last_q.delete();
            return;
        end
        hs_cyc = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        outstanding = 0; cred_viol = 0; stab_viol = 0;
        got_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        budget = int'(len) * 8 + 100;
        for (int c = 0; c < budget; c++) begin
            bus.m_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (c == 0) busy_after_hs = int'(bus.busy);
            if (bus.r_en) begin
                ren_count++;
                raddr_log.push_back(int'(bus.r_addr));
            end
            if (bus.m_valid) mvalid_count++;
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
                stab_viol++;
            // outstanding equals fifo_count + pending for this cycle
            if (outstanding + int'(bus.r_en) > int'(FD)) cred_viol++;
            if (bus.m_valid && bus.m_ready) begin
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
                n_checks++;
                if (exp_data_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got data %h last %0b, required no beat",
                             bus.m_data[31:0], bus.m_last);
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (bus.m_data !== ed || bus.m_last !== el)
                        $display("FAIL beat_%0d: got data %h last %0b, required data %h last %0b",
                                 beats, bus.m_data[31:0], bus.m_last, ed[31:0], el);
                    else
                        n_pass++;
                end
            end
            prev_stall  = bus.m_valid && !bus.m_ready;
            prev_data   = bus.m_data;
            prev_last   = bus.m_last;
            outstanding = outstanding + int'(bus.r_en) - int'(bus.m_valid && bus.m_ready);
            if (bus.done) begin
                done_cyc = cyc;
                got_done = 1'b1;
            end
            @(posedge clk); #1;
            if (got_done) break;
            if (abort_after != 0 && c + 1 >= int'(abort_after)) break;
        end
        bus.m_ready = 1'b1;
        if (abort_after == 0) begin
            n_checks++;
            if (!got_done) $display("FAIL done_timeout: done %0b after %0d cycles, required 1", got_done, budget);
            else n_pass++;
            n_checks++;
            if (exp_data_q.size() != 0) $display("FAIL beats_missing: %0d left, required 0", exp_data_q.size());
            else n_pass++;
            n_checks++;
            if (cred_viol != 0) $display("FAIL credit: %0d cycles over %0d outstanding, required 0", cred_viol, FD);
            else n_pass++;
            n_checks++;
            if (stab_viol != 0) $display("FAIL stall_stability: %0d changed stalled beats, required 0", stab_viol);
            else n_pass++;
        end
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        n_checks++;
        if ({bus.cmd_ready, bus.r_en, bus.m_valid, bus.m_last, bus.busy, bus.done} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {bus.cmd_ready, bus.r_en, bus.m_valid, bus.m_last, bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.r_addr !== '0 || bus.m_data !== '0)
            $display("FAIL reset_bus: got r_addr %0d m_data %h, required 0 0", bus.r_addr, bus.m_data[31:0]);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL reset_release: got cmd_ready %0b busy %0b, required 1 0", bus.cmd_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        drive_burst(0, 8, 0, 0);
        n_checks++;
        if (beats != 8) $display("FAIL basic_beats: got %0d, required 8", beats);
        else n_pass++;
        n_checks++;
        if (first_beat_cyc != hs_cyc + 3 || last_beat_cyc != hs_cyc + 10)
            $display("FAIL basic_timing: got first T+%0d last T+%0d, required T+3 T+10",
                     first_beat_cyc - hs_cyc, last_beat_cyc - hs_cyc);
        else n_pass++;
        n_checks++;
        if (done_cyc != hs_cyc + 11) $display("FAIL basic_done: got T+%0d, required T+11", done_cyc - hs_cyc);
        else n_pass++;
        n_checks++;
        if (busy_after_hs != 1) $display("FAIL basic_busy: got %0d at T+1, required 1", busy_after_hs);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL basic_idle_busy: got %0b after done, required 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        drive_burst(1020, 6, 0, 0);
        n_checks++;
        if (raddr_log.size() != 6) $display("FAIL wrap_reads: got %0d, required 6", raddr_log.size());
        else n_pass++;
        for (int i = 0; i < raddr_log.size() && i < 6; i++) begin
            n_checks++;
            if (raddr_log[i] != (1020 + i) % 1024)
                $display("FAIL wrap_addr_%0d: got %0d, required %0d", i, raddr_log[i], (1020 + i) % 1024);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        drive_burst(100, 16, 30, 0);
        n_checks++;
        if (beats != 16 || ren_count != 16)
            $display("FAIL bp_counts: got beats %0d reads %0d, required 16 16", beats, ren_count);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        drive_burst(33, 0, 0, 0);
        n_checks++;
        if (ren_count != 0 || mvalid_count != 0)
            $display("FAIL zero_len_activity: got reads %0d valids %0d, required 0 0", ren_count, mvalid_count);
        else n_pass++;
        n_checks++;
        if (done_cyc != hs_cyc + 1) $display("FAIL zero_len_done: got T+%0d, required T+1", done_cyc - hs_cyc);
        else n_pass++;
        drive_burst(5, 1, 0, 0);
        n_checks++;
        if (beats != 1 || done_cyc != hs_cyc + 4)
            $display("FAIL single_beat: got beats %0d done T+%0d, required 1 T+4", beats, done_cyc - hs_cyc);
        else n_pass++;
    endtask

    task automatic test_full_depth();
        int cnt [1024];
        int bad;
        drive_burst(512, 1024, 0, 0);
        for (int i = 0; i < 1024; i++) cnt[i] = 0;
        foreach (raddr_log[i]) cnt[raddr_log[i]]++;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cnt[i] != 1) bad++;
        n_checks++;
        if (bad != 0 || ren_count != 1024)
            $display("FAIL full_addr_cover: got %0d bad addresses %0d reads, required 0 1024", bad, ren_count);
        else n_pass++;
        n_checks++;
        if (beats != 1024 || done_cyc != hs_cyc + 1027)
            $display("FAIL full_done: got beats %0d done T+%0d, required 1024 T+1027", beats, done_cyc - hs_cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        drive_burst(512, 1024, 0, 300);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.r_en, bus.m_valid, bus.m_last, bus.busy, bus.done} !== 6'b0)
            $display("FAIL midrst_ctrl: got %b, required 000000",
                     {bus.cmd_ready, bus.r_en, bus.m_valid, bus.m_last, bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.r_addr !== '0 || bus.m_data !== '0)
            $display("FAIL midrst_bus: got r_addr %0d m_data %h, required 0 0", bus.r_addr, bus.m_data[31:0]);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.m_valid !== 1'b0)
                $display("FAIL midrst_hold_%0d: got done %0b m_valid %0b, required 0 0", i, bus.done, bus.m_valid);
            else n_pass++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.r_en !== 1'b0)
                $display("FAIL midrst_after_%0d: got done %0b r_en %0b, required 0 0", i, bus.done, bus.r_en);
            else n_pass++;
        end
        @(posedge clk); #1;
        drive_burst(1000, 40, 0, 0);
        n_checks++;
        if (beats != 40 || done_cyc != hs_cyc + 43)
            $display("FAIL post_rst_burst: got beats %0d done T+%0d, required 40 T+43", beats, done_cyc - hs_cyc);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int unsigned i = 0; i < 1024; i++) ram[i] = word(i);
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b1;
        bus.r_data    = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_depth();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
